serial_word_assembler: RTL
==========================

SERIAL_WORD_ASSEMBLER -- requirements
Module: serial_word_assembler

Interface
REQ-001 Parameter WIDTH, default 4: data bits per word; legal values are 2 and above.
REQ-002 Parameter PARITY_EN, default 1: 1 = one even-parity bit follows the data bits; 0 = no parity bit.
REQ-003 Parameter MSB_FIRST, default 0: 0 = first data bit lands in o_word[0]; 1 = first data bit lands in o_word[WIDTH-1].
REQ-004 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-low.
REQ-006 i_bit  input  1  serial data bit.
REQ-007 i_bit_valid  input  1  i_bit is valid this cycle.
REQ-008 i_frame_start  input  1  qualifies the current valid bit as data bit 0 of a new frame.
REQ-009 i_word_ready  input  1  downstream accepts o_word this cycle.
REQ-010 o_bit_ready  output  1  block can accept a bit this cycle.
REQ-011 o_word  output  WIDTH  assembled word, ready to drive a parallel-load input.
REQ-012 o_word_valid  output  1  o_word holds an unconsumed word.
REQ-013 o_load_pulse  output  1  one-cycle pulse when a new word enters o_word, for use as a load enable.
REQ-014 o_parity_err  output  1  parity status of the word in o_word; meaningful only while o_word_valid=1.
REQ-015 o_overflow  output  1  one-cycle pulse when a bit is offered while o_bit_ready=0.

Function
REQ-016 A bit SHALL be accepted on an edge where i_bit_valid=1 and o_bit_ready=1.
REQ-017 The FSM SHALL have four states:
- IDLE
- DATA: bit counter 0..WIDTH-1
- PARITY
- WAIT
REQ-018 IDLE SHALL behave as follows:
- o_bit_ready=1.
- An accepted bit with i_frame_start=0 is discarded.
- An accepted bit with i_frame_start=1 is stored as data bit 0, and the FSM goes to DATA with count=1.
REQ-019 In DATA, each accepted bit SHALL be stored at position count (mirrored when MSB_FIRST=1), and count increments.
REQ-020 When data bit WIDTH-1 is accepted, the FSM SHALL go to PARITY if PARITY_EN=1; otherwise the frame completes.
REQ-021 In PARITY, the accepted bit SHALL complete the frame; the error flag = XOR of the WIDTH data bits and the parity bit (1 means error).
REQ-022 In DATA or PARITY, an accepted bit with i_frame_start=1 SHALL discard the partial frame and restart as data bit 0, with count=1 and state DATA.
REQ-023 Frame completion SHALL transfer the frame to the output registers based on output-register state:
- If o_word_valid=0, or o_word_valid=1 with i_word_ready=1 on the same edge: transfer on that edge. o_word, o_parity_err and o_word_valid=1 appear the next cycle; o_load_pulse=1 for exactly that cycle; the FSM goes to IDLE.
- Otherwise: the frame is held in a staging register and the FSM goes to WAIT.
REQ-024 WAIT SHALL behave as follows:
- o_bit_ready=0.
- On an edge with i_word_ready=1, the staged word moves to o_word with o_word_valid=1 kept, o_load_pulse=1 for the next cycle, and the FSM goes to IDLE.
REQ-025 o_word_valid SHALL clear on an edge with i_word_ready=1 unless a new word is loaded on the same edge; o_word holds its value while o_word_valid=0.
REQ-026 o_overflow SHALL pulse for one cycle following any edge with i_bit_valid=1 and o_bit_ready=0; the offered bit is dropped.
REQ-027 Latency SHALL be 1 cycle from the final bit's acceptance edge to o_word_valid=1 when the output register is free.
REQ-028 Throughput SHALL be one bit per cycle with no bubble between frames while downstream keeps up.

Reset
REQ-029 While i_rst=0, the block SHALL hold, asynchronously:
- state=IDLE, count=0
- o_word=0, staging register=0
- o_word_valid=0, o_load_pulse=0, o_parity_err=0, o_overflow=0
- o_bit_ready=1
REQ-030 Reset asserted mid-frame or in WAIT SHALL discard all partial and staged data; the first edge after release behaves as IDLE.

Verification
REQ-031 Release reset with no stimulus -> all outputs equal their REQ-029 reset values; o_bit_ready=1.
REQ-032 WIDTH=4, PARITY_EN=1, MSB_FIRST=0; bits 1(start),0,1,1 then parity 1 -> next cycle o_word=4'b1101, o_word_valid=1, o_load_pulse=1 for one cycle, o_parity_err=0.
REQ-033 Same data with parity bit 0 -> o_word=4'b1101, o_parity_err=1.
REQ-034 Hold i_word_ready=0; send two full frames (0xA then 0x5):
- FSM enters WAIT and o_bit_ready=0.
- A further offered bit gives a one-cycle o_overflow pulse.
- Raising i_word_ready consumes 0xA; o_word=0x5 the next cycle.
REQ-035 Send bits 1,1 then a new start bit with data 0,0,0,0 and parity 0 -> o_word=4'b0000, o_parity_err=0; the partial frame does not appear.
REQ-036 Assert i_rst=0 after two data bits, release, then send a full frame 0x3 -> only 0x3 is delivered, with no stale bits.

Source files
------------

// File: rtl/serial_word_assembler_if.sv
// Serial bit stream in, parallel word out.
// Slave side is the assembler, master side the surrounding logic.
interface serial_word_assembler_if #(
  parameter int WIDTH = 4
);
  logic             i_bit;
  logic             i_bit_valid;
  logic             i_frame_start;
  logic             i_word_ready;
  logic             o_bit_ready;
  logic [WIDTH-1:0] o_word;
  logic             o_word_valid;
  logic             o_load_pulse;
  logic             o_parity_err;
  logic             o_overflow;

  modport slave (
    input  i_bit,
    input  i_bit_valid,
    input  i_frame_start,
    input  i_word_ready,
    output o_bit_ready,
    output o_word,
    output o_word_valid,
    output o_load_pulse,
    output o_parity_err,
    output o_overflow
  );

  modport master (
    output i_bit,
    output i_bit_valid,
    output i_frame_start,
    output i_word_ready,
    input  o_bit_ready,
    input  o_word,
    input  o_word_valid,
    input  o_load_pulse,
    input  o_parity_err,
    input  o_overflow
  );
endinterface

// File: rtl/serial_word_assembler.sv
// Collects framed serial bits into a WIDTH-bit word with optional
// even parity, one staging slot and a registered output word.
module serial_word_assembler #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1,
  parameter int MSB_FIRST = 0
) (
  input logic                   i_clk,
  input logic                   i_rst,
  serial_word_assembler_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] stage_q, stage_d;
  logic             stage_err_q, stage_err_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             load_q, load_d;
  logic             ovf_q, ovf_d;

  logic             bit_rdy;
  logic             acc;
  logic             done;
  logic [WIDTH-1:0] done_word;
  logic             done_err;
  logic [CW-1:0]    pidx;
  logic [CW-1:0]    p0;
  logic [WIDTH-1:0] ins;
  logic [WIDTH-1:0] first;

  assign bit_rdy = (state_q != WAIT);
  assign acc     = bus.i_bit_valid & bit_rdy;

  // Bit position for the current count and for data bit 0
  always_comb begin
    pidx  = cnt_q;
    p0    = '0;
    if (MSB_FIRST != 0) begin
      pidx = CW'(WIDTH - 1) - cnt_q;
      p0   = CW'(WIDTH - 1);
    end
    ins   = data_q;
    first = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (CW'(i) == pidx) ins[i] = bus.i_bit;
      if (CW'(i) == p0) first[i] = bus.i_bit;
    end
  end

  // Next-state: frame FSM, staging slot and output register
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    stage_d     = stage_q;
    stage_err_d = stage_err_q;
    word_d      = word_q;
    err_d       = err_q;
    valid_d     = valid_q & ~bus.i_word_ready;
    load_d      = 1'b0;
    ovf_d       = bus.i_bit_valid & ~bit_rdy;
    done        = 1'b0;
    done_word   = data_q;
    done_err    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (acc && bus.i_frame_start) begin
          data_d  = first;
          cnt_d   = CW'(1);
          state_d = DATA;
        end
      end
      DATA: begin
        if (acc) begin
          if (bus.i_frame_start) begin
            data_d = first;
            cnt_d  = CW'(1);
          end else begin
            data_d = ins;
            if (cnt_q == CW'(WIDTH - 1)) begin
              cnt_d = '0;
              if (PARITY_EN != 0) begin
                state_d = PARITY;
              end else begin
                done      = 1'b1;
                done_word = ins;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end
      PARITY: begin
        if (acc) begin
          if (bus.i_frame_start) begin
            data_d  = first;
            cnt_d   = CW'(1);
            state_d = DATA;
          end else begin
            done      = 1'b1;
            done_word = data_q;
            done_err  = ^{data_q, bus.i_bit};
          end
        end
      end
      WAIT: begin
        if (bus.i_word_ready) begin
          word_d  = stage_q;
          err_d   = stage_err_q;
          valid_d = 1'b1;
          load_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      if (!valid_q || bus.i_word_ready) begin
        word_d  = done_word;
        err_d   = done_err;
        valid_d = 1'b1;
        load_d  = 1'b1;
        state_d = IDLE;
      end else begin
        stage_d     = done_word;
        stage_err_d = done_err;
        state_d     = WAIT;
      end
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      stage_q     <= '0;
      stage_err_q <= 1'b0;
      word_q      <= '0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      load_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      stage_q     <= stage_d;
      stage_err_q <= stage_err_d;
      word_q      <= word_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
      load_q      <= load_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.o_bit_ready  = bit_rdy;
  assign bus.o_word       = word_q;
  assign bus.o_word_valid = valid_q;
  assign bus.o_load_pulse = load_q;
  assign bus.o_parity_err = err_q;
  assign bus.o_overflow   = ovf_q;

endmodule
